// File: rtl/prog_seq_det.sv
// Serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping matching, and a saturating match counter.
module prog_seq_det #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               armed,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_n;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic               len_legal;
    logic               accept;
    logic               hit;

    assign len_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    // A load in the same cycle as a valid bit discards that bit.
    assign accept    = (state == RUN) && in_valid && !cfg_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the block leaves state_n unassigned (no latch).
        state_n = state;
        if (cfg_load) begin
            state_n = len_legal ? RUN : IDLE;
        end
    end

    always_comb begin
        armed = (state == RUN);
    end

    // Candidate history/fill for the bit on the line; only committed when accepted.
    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], in_bit};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(cfg_len));
        end
        hit = accept && (fill_n >= cfg_len) && (((hist_n ^ cfg_pat) & len_mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cfg_pat     <= '0;
            cfg_len     <= '0;
            cfg_ovl     <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (cfg_load) begin
            cfg_pat     <= pat;
            cfg_len     <= pat_len;
            cfg_ovl     <= overlap;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;
            if (accept) begin
                hist <= hist_n;
                fill <= (hit && !cfg_ovl) ? '0 : fill_n;
            end
            if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule
